// File: rtl/adam_periph_uart_pkg.sv
// adam_periph_uart_pkg: shared types and helpers for the ADAM UART peripheral
//   uart_tx_arb_state_t : state encoding of the UART TX stream arbiter
//   idw()               : index width for n requesters, never below one bit
package adam_periph_uart_pkg;

    typedef enum logic [1:0] {PAUSED, IDLE, GRANT} uart_tx_arb_state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adam_rr_pick.sv
// adam_rr_pick: combinational round-robin picker
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority; priority falls with distance ptr, ptr+1, ... mod NO_MSTS
//   found : at least one request is set
//   idx   : first requesting index at or after ptr (0 when nothing is found)
module adam_rr_pick
    import adam_periph_uart_pkg::*;
#(
    parameter int NO_MSTS = 4,
    localparam int IDW = idw(NO_MSTS)
) (
    input  logic [NO_MSTS-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);

    logic [2*NO_MSTS-1:0] dbl;
    logic [NO_MSTS-1:0]   rot;

    // rot[k] is the request at (ptr + k) mod NO_MSTS
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NO_MSTS-1:0];

    always_comb begin
        found = |req;
        idx   = '0;
        // scan from the far end so the nearest request wins
        for (int k = NO_MSTS - 1; k >= 0; k--) begin
            if (rot[k]) idx = IDW'((int'(ptr) + k) % NO_MSTS);
        end
    end

endmodule

// File: rtl/adam_periph_uart_tx_arb.sv
// adam_periph_uart_tx_arb: round-robin burst arbiter in front of the UART TX stream
//   clk, rst   : clock, asynchronous active-low reset
//   pause_req  : pause request; pause_ack acknowledges once no word is in flight
//   slv_*      : NO_MSTS requester streams (data/valid in, ready out)
//   mst_*      : single stream towards the UART TX slave port
//   grant_id   : current or last grantee
//   busy       : high while a requester holds the grant
module adam_periph_uart_tx_arb
    import adam_periph_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NO_MSTS    = 4,
    parameter int MAX_BURST  = 16,
    localparam int IDW = idw(NO_MSTS)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pause_req,
    output logic                                pause_ack,
    input  logic [NO_MSTS-1:0][DATA_WIDTH-1:0]  slv_data,
    input  logic [NO_MSTS-1:0]                  slv_valid,
    output logic [NO_MSTS-1:0]                  slv_ready,
    output logic [DATA_WIDTH-1:0]               mst_data,
    output logic                                mst_valid,
    input  logic                                mst_ready,
    output logic [IDW-1:0]                      grant_id,
    output logic                                busy
);

    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NO_MSTS - 1);
    localparam logic [NO_MSTS-1:0] ONE   = NO_MSTS'(1);

    uart_tx_arb_state_t state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] next_ptr;
    logic [BCW-1:0] beat_cnt;
    logic           pick_found;
    logic           in_grant;
    logic           hs;
    logic           release_now;

    adam_rr_pick #(.NO_MSTS(NO_MSTS)) u_pick (
        .req   (slv_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // pure pass-through of the grantee; mst_valid never depends on mst_ready
    assign in_grant  = state == GRANT;
    assign mst_data  = slv_data[grant_id];
    assign mst_valid = in_grant & slv_valid[grant_id];
    assign slv_ready = (in_grant & mst_ready) ? ONE << grant_id : '0;
    assign hs        = mst_valid & mst_ready;
    assign next_ptr  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

    // a stalled word (valid & !ready) blocks the pause term, so it is never withdrawn
    assign release_now = (hs & (beat_cnt == LAST_BEAT))
                       | ~slv_valid[grant_id]
                       | (pause_req & (~mst_valid | hs));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= PAUSED;
            ptr       <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            pause_ack <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= IDLE;
                        pause_ack <= 1'b0;
                    end
                end
                IDLE: begin
                    if (pause_req) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end else if (pick_found) begin
                        state    <= GRANT;
                        grant_id <= pick_idx;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (hs) beat_cnt <= beat_cnt + 1'b1;
                    // always pass through IDLE so the next grant sees the rotated pointer
                    if (release_now) begin
                        ptr       <= next_ptr;
                        state     <= pause_req ? PAUSED : IDLE;
                        pause_ack <= pause_req;
                        busy      <= 1'b0;
                    end
                end
                default: state <= PAUSED;
            endcase
        end
    end

endmodule

// File: tb/tb_adam_periph_uart_tx_arb.sv
// tb_adam_periph_uart_tx_arb: scoreboard bench for the UART TX stream arbiter
module tb_adam_periph_uart_tx_arb;

    localparam int DW  = 32;
    localparam int N   = 4;
    localparam int MB  = 16;
    localparam int IDW = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pause_req;
    logic                 pause_ack;
    logic [N-1:0][DW-1:0] slv_data;
    logic [N-1:0]         slv_valid;
    logic [N-1:0]         slv_ready;
    logic [DW-1:0]        mst_data;
    logic                 mst_valid;
    logic                 mst_ready;
    logic [IDW-1:0]       grant_id;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb[$];
    int bursts_obs[$];
    int bursts_exp[$];
    int run = 0;
    int gap = 0;
    int exp_gap = 0;
    int hs_count = 0;

    bit en[N];
    int left[N];
    int seq[N];
    int exp_seq[N];

    always #5 clk = ~clk;

    adam_periph_uart_tx_arb #(
        .DATA_WIDTH (DW),
        .NO_MSTS    (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pause_req (pause_req),
        .pause_ack (pause_ack),
        .slv_data  (slv_data),
        .slv_valid (slv_valid),
        .slv_ready (slv_ready),
        .mst_data  (mst_data),
        .mst_valid (mst_valid),
        .mst_ready (mst_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int i, input int s);
        return {8'(i), 24'(s)};
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            slv_valid[i] = en[i] && left[i] > 0;
            slv_data[i]  = word(i, seq[i]);
        end
    endtask

    // sample at negedge (the handshake that the next posedge will commit), then re-drive
    task automatic cyc();
        logic [DW-1:0] e;
        @(negedge clk);
        if (mst_valid && mst_ready) begin
            e = (sb.size() > 0) ? sb.pop_front() : '1;
            check("data", mst_data, e);
            check("grant_id", grant_id, e[25:24]);
            if (run == 0 && exp_gap > 0 && hs_count > 0) check("gap", gap, exp_gap);
            run++;
            hs_count++;
            gap = 0;
        end else begin
            if (run > 0) begin
                bursts_obs.push_back(run);
                run = 0;
            end
            gap++;
        end
        for (int i = 0; i < N; i++) begin
            if (slv_valid[i] && slv_ready[i]) begin
                seq[i]++;
                left[i]--;
            end
        end
        @(posedge clk);
        #1;
        drive();
        #1;
    endtask

    task automatic begin_test();
        sb.delete();
        bursts_obs.delete();
        bursts_exp.delete();
        run = 0;
        gap = 0;
        hs_count = 0;
        for (int i = 0; i < N; i++) exp_seq[i] = seq[i];
    endtask

    task automatic push(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back(word(i, exp_seq[i]));
            exp_seq[i]++;
        end
    endtask

    task automatic end_test();
        for (int k = 0; k < 300 && sb.size() > 0; k++) cyc();
        repeat (3) cyc();
        check("drained", sb.size(), 0);
        check("bursts", bursts_obs.size(), bursts_exp.size());
        for (int i = 0; i < bursts_obs.size() && i < bursts_exp.size(); i++)
            check("burst_len", bursts_obs[i], bursts_exp[i]);
    endtask

    initial begin
        rst = 1'b1;
        pause_req = 1'b1;
        mst_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0;
            left[i] = 0;
            seq[i] = 0;
        end
        drive();
        #1 rst = 1'b0;
        #1;
        check("rst_pause_ack", pause_ack, 1);
        check("rst_busy", busy, 0);
        check("rst_mst_valid", mst_valid, 0);
        check("rst_slv_ready", slv_ready, 0);
        check("rst_grant_id", grant_id, 0);
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        cyc();
        check("pause_held", pause_ack, 1);
        pause_req = 1'b0;
        cyc();
        check("pause_ack_fall", pause_ack, 0);
        check("idle_busy", busy, 0);

        // requester 2 alone, 40 words, UART always ready
        begin_test();
        exp_gap = 1;
        mst_ready = 1'b1;
        en[2] = 1'b1;
        left[2] = 40;
        push(2, 40);
        bursts_exp = '{16, 16, 8};
        drive();
        #1;
        check("lat_idle", mst_valid, 0);
        cyc();
        check("lat_grant", mst_valid, 1);
        check("lat_busy", busy, 1);
        end_test();

        // UART stall with pause request: grant held until the word goes
        begin_test();
        exp_gap = 0;
        mst_ready = 1'b0;
        en[1] = 1'b1;
        left[1] = 4;
        push(1, 4);
        bursts_exp = '{1, 3};
        drive();
        cyc();
        check("stall_valid", mst_valid, 1);
        pause_req = 1'b1;
        cyc();
        cyc();
        check("stall_ack", pause_ack, 0);
        check("stall_busy", busy, 1);
        check("stall_gid", grant_id, 1);
        check("stall_data", mst_data, word(1, 0));
        mst_ready = 1'b1;
        cyc();
        check("pause_ack_rise", pause_ack, 1);
        check("pause_busy", busy, 0);
        check("pause_valid", mst_valid, 0);
        pause_req = 1'b0;
        cyc();
        check("unpause_ack", pause_ack, 0);
        end_test();

        // asynchronous reset after 7 beats of a burst
        begin_test();
        exp_gap = 0;
        mst_ready = 1'b1;
        en[2] = 1'b1;
        left[2] = 10;
        push(2, 7);
        bursts_exp = '{7};
        drive();
        for (int k = 0; k < 50 && hs_count < 7; k++) cyc();
        check("beats_before_rst", hs_count, 7);
        rst = 1'b0;
        #1;
        check("arst_pause_ack", pause_ack, 1);
        check("arst_busy", busy, 0);
        check("arst_mst_valid", mst_valid, 0);
        check("arst_slv_ready", slv_ready, 0);
        check("arst_grant_id", grant_id, 0);
        en[2] = 1'b0;
        left[2] = 0;
        drive();
        cyc();
        rst = 1'b1;
        cyc();
        check("arst_unpause", pause_ack, 0);
        end_test();

        // requester 0 stops after 3 words while 3 waits: release, then 3 after one IDLE
        begin_test();
        exp_gap = 2;
        en[0] = 1'b1;
        left[0] = 3;
        en[3] = 1'b1;
        left[3] = 2;
        push(0, 3);
        push(3, 2);
        bursts_exp = '{3, 2};
        drive();
        end_test();

        // all four continuously valid: 0,1,2,3,0 with full bursts
        begin_test();
        exp_gap = 1;
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            left[i] = (i == 0) ? 32 : 16;
        end
        push(0, 16);
        push(1, 16);
        push(2, 16);
        push(3, 16);
        push(0, 16);
        bursts_exp = '{16, 16, 16, 16, 16};
        drive();
        end_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
